fetch_npc_unit: RTL and testbench

IF-stage PC register, next-PC selection and IF/ID pipeline register for the 5-stage MIPS core.
- Consumes the ID-stage comparator results (cmp_eq from the beq comparator, cmp_ne from the bne comparator) and the forwarded rs value.
- Decodes the control-transfer class of the instruction currently in ID.
- Redirects fetch with MIPS delay-slot semantics: the delay slot is never flushed.
- Feeds instr_d/pc_d to the decoder and to both comparators, and link_d to the GRF write-data mux.

---
 rtl/mips_defs.sv | 11 +
 rtl/npc_sel.sv | 33 +++
 rtl/fetch_npc_unit.sv | 52 +++++
 tb/tb_fetch_npc_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs: opcode/funct constants and npc-select encoding shared by the fetch stage
package mips_defs;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_sel_e;
endpackage

// File: rtl/npc_sel.sv
// npc_sel: decode the ID-stage control transfer and form the raw next fetch address
module npc_sel
  import mips_defs::*;
(
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_f,
  input  logic        cmp_eq,
  input  logic        cmp_ne,
  input  logic [31:0] rs_val_d,
  output logic [31:0] npc,
  output logic        redirect
);
  logic [5:0] op;
  logic [31:0] seq, br_tgt, j_tgt;
  logic taken;
  npc_sel_e sel;
  always_comb begin
    op = instr_d[31:26];
    seq = pc_f + 32'd4;
    br_tgt = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    j_tgt = {pc_d[31:28], instr_d[25:0], 2'b00};
    taken = (op == OP_BEQ && cmp_eq) || (op == OP_BNE && cmp_ne);
    sel = taken ? NPC_BR :
          (op == OP_J || op == OP_JAL) ? NPC_J :
          (op == OP_SPECIAL && instr_d[5:0] == FN_JR) ? NPC_JR : NPC_SEQ;
    // jr keeps the raw rs value so the parent can flag a misaligned target
    npc = sel == NPC_BR ? br_tgt :
          sel == NPC_J  ? j_tgt :
          sel == NPC_JR ? rs_val_d : seq;
    redirect = npc != seq;
  end
endmodule

// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: IF-stage PC register, IF/ID register and sticky fetch address error
module fetch_npc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
  parameter logic [31:0] IM_LO = 32'h0000_3000,
  parameter logic [31:0] IM_HI = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic        cmp_eq,
  input  logic        cmp_ne,
  input  logic [31:0] rs_val_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] link_d,
  output logic        redirect,
  output logic        addr_err
);
  logic [31:0] npc;
  logic bad;
  npc_sel u_npc_sel (
    .instr_d(instr_d),
    .pc_d(pc_d),
    .pc_f(pc_f),
    .cmp_eq(cmp_eq),
    .cmp_ne(cmp_ne),
    .rs_val_d(rs_val_d),
    .npc(npc),
    .redirect(redirect)
  );
  always_comb begin
    link_d = pc_d + 32'd8;
    bad = (npc[1:0] != 2'b00) || (npc < IM_LO) || (npc > IM_HI);
  end
  // a stalled branch commits nothing; it is re-decided on the first unstalled edge
  always_ff @(posedge clk)
    if (reset) begin
      pc_f <= RESET_PC;
      instr_d <= '0;
      pc_d <= '0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      pc_f <= {npc[31:2], 2'b00};
      instr_d <= instr_f;
      pc_d <= pc_f;
      addr_err <= addr_err | bad;
    end
endmodule

// File: tb/tb_fetch_npc_unit.sv
// tb_fetch_npc_unit: directed fetch/redirect sequence with immediate-assertion checks
module tb_fetch_npc_unit;
  logic clk = 1'b0;
  logic reset, stall, cmp_eq, cmp_ne, redirect, addr_err;
  logic [31:0] instr_f, rs_val_d, pc_f, instr_d, pc_d, link_d;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ADDI = 32'h2000_0001;
  localparam logic [31:0] BEQ4 = 32'h1000_0004;
  localparam logic [31:0] BNEM4 = 32'h1400_FFFC;
  localparam logic [31:0] J301C = 32'h0800_0C07;
  localparam logic [31:0] J3040 = 32'h0800_0C10;
  localparam logic [31:0] JAL3040 = 32'h0C00_0C10;
  localparam logic [31:0] JR31 = 32'h03E0_0008;

  fetch_npc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f),
    .cmp_eq(cmp_eq), .cmp_ne(cmp_ne), .rs_val_d(rs_val_d),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .link_d(link_d),
    .redirect(redirect), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall = 0; instr_f = NOP; cmp_eq = 0; cmp_ne = 0; rs_val_d = 0;
    step();
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_instr_d", instr_d, 0);
    chk("rst_pc_d", pc_d, 0);
    chk("rst_addr_err", {31'b0, addr_err}, 0);
    chk("rst_redirect", {31'b0, redirect}, 0);
    chk("rst_link", link_d, 32'h8);
    reset = 0;
    step(); chk("seq1", pc_f, 32'h3004);
    step(); chk("seq2", pc_f, 32'h3008);
    step(); chk("seq3", pc_f, 32'h300C);
    step(); chk("seq4", pc_f, 32'h3010);
    instr_f = BEQ4;
    step();
    chk("beq_pc_d", pc_d, 32'h3010);
    cmp_eq = 1; instr_f = ADDI;
    #1 chk("beq_redirect", {31'b0, redirect}, 1);
    step();
    chk("beq_taken", pc_f, 32'h3024);
    chk("delay_slot", instr_d, ADDI);
    chk("delay_slot_pc", pc_d, 32'h3014);
    cmp_eq = 0;
    #1 chk("after_beq_redirect", {31'b0, redirect}, 0);
    instr_f = BEQ4;
    step();
    #1 chk("beq_nt_redirect", {31'b0, redirect}, 0);
    instr_f = NOP;
    step(); chk("beq_not_taken", pc_f, 32'h302C);
    instr_f = J301C;
    step();
    #1 chk("j_redirect", {31'b0, redirect}, 1);
    instr_f = NOP;
    step(); chk("j_target", pc_f, 32'h301C);
    step(); chk("seq_3020", pc_f, 32'h3020);
    instr_f = BNEM4;
    step();
    chk("bne_pc_d", pc_d, 32'h3020);
    stall = 1; cmp_ne = 0;
    #1 chk("bne_stall_nt", {31'b0, redirect}, 0);
    step();
    chk("stall_hold_pc", pc_f, 32'h3024);
    chk("stall_hold_instr", instr_d, BNEM4);
    cmp_ne = 1;
    #1 chk("bne_stall_t", {31'b0, redirect}, 1);
    step();
    chk("stall_hold_pc2", pc_f, 32'h3024);
    chk("stall_hold_pc_d", pc_d, 32'h3020);
    stall = 0; instr_f = NOP;
    step();
    chk("bne_taken", pc_f, 32'h3014);
    cmp_ne = 0; instr_f = J3040;
    step();
    instr_f = NOP;
    step(); chk("j_3040", pc_f, 32'h3040);
    instr_f = JAL3040;
    step();
    chk("jal_link", link_d, 32'h3048);
    chk("jal_redirect", {31'b0, redirect}, 1);
    instr_f = NOP;
    step(); chk("jal_target", pc_f, 32'h3040);
    instr_f = JR31; rs_val_d = 32'h3048;
    step();
    instr_f = NOP;
    step();
    chk("jr_target", pc_f, 32'h3048);
    chk("jr_no_err", {31'b0, addr_err}, 0);
    instr_f = JR31; rs_val_d = 32'h3002;
    step();
    instr_f = NOP;
    step();
    chk("jr_misalign_pc", pc_f, 32'h3000);
    chk("jr_misalign_err", {31'b0, addr_err}, 1);
    step();
    chk("err_sticky", {31'b0, addr_err}, 1);
    chk("err_sticky_pc", pc_f, 32'h3004);
    reset = 1;
    step();
    chk("err_cleared", {31'b0, addr_err}, 0);
    reset = 0; instr_f = JR31; rs_val_d = 32'h8000;
    step();
    instr_f = NOP;
    step();
    chk("jr_range_pc", pc_f, 32'h8000);
    chk("jr_range_err", {31'b0, addr_err}, 1);
    reset = 1;
    step();
    reset = 0; instr_f = BEQ4;
    step();
    chk("beq2_instr_d", instr_d, BEQ4);
    stall = 1; cmp_eq = 1; instr_f = NOP;
    step();
    chk("beq2_stall_hold", pc_f, 32'h3004);
    reset = 1;
    step();
    chk("rst2_pc_f", pc_f, 32'h3000);
    chk("rst2_instr_d", instr_d, 0);
    chk("rst2_pc_d", pc_d, 0);
    chk("rst2_err", {31'b0, addr_err}, 0);
    reset = 0; stall = 0; cmp_eq = 1'bx;
    #1 chk("x_cmp_ignored", {31'b0, redirect}, 0);
    step();
    chk("branch_discarded", pc_f, 32'h3004);
    cmp_eq = 0; instr_f = JR31; rs_val_d = 32'h6FFC;
    step();
    instr_f = NOP;
    step();
    chk("jr_hi_pc", pc_f, 32'h6FFC);
    chk("jr_hi_no_err", {31'b0, addr_err}, 0);
    step();
    chk("seq_past_hi_pc", pc_f, 32'h7000);
    chk("seq_past_hi_err", {31'b0, addr_err}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
